// File: rtl/poly_unpack_pkg.sv
// Shared types and constants for the streaming polynomial coefficient unpacker.
package poly_unpack_pkg;

  localparam int KYBER_Q = 3329;
  localparam int D_MAX   = 12;

  typedef enum logic [3:0] {
    D_4  = 4'd4,
    D_5  = 4'd5,
    D_10 = 4'd10,
    D_11 = 4'd11,
    D_12 = 4'd12
  } d_t;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  function automatic bit is_legal_d(input logic [3:0] d);
    return d inside {D_4, D_5, D_10, D_11, D_12};
  endfunction

  // One full input beat plus one full output group at the widest coefficient.
  function automatic int max_buf_bits(input int in_bytes, input int out_n);
    return 8 * in_bytes + out_n * D_MAX;
  endfunction

endpackage

// File: rtl/poly_unpack_lane_extract.sv
// Slices OUT_N coefficients of width d from the head of the bit buffer and
// zero-extends each into a COEF_W lane (coefficient 0 in the MSB lane).
module poly_unpack_lane_extract
  import poly_unpack_pkg::*;
#(
  parameter int OUT_N  = 8,
  parameter int COEF_W = 16
) (
  input  logic [OUT_N*D_MAX-1:0]  bits,
  input  logic [3:0]              d,
  output logic [OUT_N*COEF_W-1:0] lanes
);

  logic [D_MAX-1:0] v;

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    lanes = '0;
    v     = '0;
    for (int k = 0; k < OUT_N; k++) begin
      case (d)
        D_4:     v = D_MAX'(bits[k*4 +: 4]);
        D_5:     v = D_MAX'(bits[k*5 +: 5]);
        D_10:    v = D_MAX'(bits[k*10 +: 10]);
        D_11:    v = D_MAX'(bits[k*11 +: 11]);
        D_12:    v = bits[k*12 +: 12];
        default: v = '0;
      endcase
      lanes[(OUT_N-1-k)*COEF_W +: COEF_W] = COEF_W'(v);
    end
  end

endmodule

// File: rtl/poly_unpack_stream.sv
// Streaming byte-to-coefficient unpacker with per-polynomial framing.
// Optional range check on 12-bit lanes enabled by POLY_UNPACK_RANGE_CHECK_EN.
module poly_unpack_stream #(
  parameter int IN_BYTES = 12,
  parameter int OUT_N    = 8,
  parameter int COEF_W   = 16,
  parameter int N        = 256,
  parameter int KYBER_Q  = poly_unpack_pkg::KYBER_Q
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              d_sel,
  input  logic [8*IN_BYTES-1:0]   in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [OUT_N*COEF_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    out_err
);
  import poly_unpack_pkg::*;

  localparam int IN_W   = 8 * IN_BYTES;
  localparam int LANE_W = OUT_N * D_MAX;
  localparam int BUF_W  = max_buf_bits(IN_BYTES, OUT_N);
  localparam int CNT_W  = $clog2(BUF_W + 1);
  localparam int CCNT_W = $clog2(N + 1);
  localparam int REM_W  = $clog2(N * D_MAX + 1);
  localparam int OUT_W  = OUT_N * COEF_W;

  if ((N % OUT_N) != 0 || KYBER_Q >= (1 << D_MAX)) begin : g_bad_cfg
    $error("poly_unpack_stream: unsupported parameter set");
  end

  state_t            state_q, state_n;
  logic [3:0]        d_q, d_n;
  logic [BUF_W-1:0]  bit_buf, buf_n, in_ext;
  logic [CNT_W-1:0]  count, count_n, kept, sh_out, grp_q, grp_n;
  logic [CCNT_W-1:0] coef_cnt, coef_n;
  logic [REM_W-1:0]  remaining;
  logic              in_fire, out_fire, out_valid_n, out_last_n;
  logic [OUT_W-1:0]  lanes_n;

  assign grp_q     = CNT_W'(OUT_N * int'(d_q));
  assign grp_n     = CNT_W'(OUT_N * int'(d_n));
  assign remaining = REM_W'((N - int'(coef_cnt)) * int'(d_q));

  // Stop accepting once the buffer already holds the rest of this polynomial.
  assign in_ready = (state_q == RUN)
                 && ((CNT_W'(BUF_W) - count) >= CNT_W'(IN_W))
                 && (REM_W'(count) < remaining);

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Byte 0 arrives at the MSB end; the buffer keeps the oldest bit at index 0.
  always_comb begin
    in_ext = '0;
    for (int i = 0; i < IN_BYTES; i++)
      in_ext[8*i +: 8] = in_data[8*(IN_BYTES-1-i) +: 8];
  end

  always_comb begin
    state_n = state_q;
    d_n     = d_q;
    buf_n   = bit_buf;
    count_n = count;
    coef_n  = coef_cnt;
    sh_out  = out_fire ? grp_q : '0;
    kept    = count - sh_out;
    case (state_q)
      IDLE: begin
        if (is_legal_d(d_sel)) begin
          state_n = RUN;
          d_n     = d_sel;
        end
      end
      RUN: begin
        buf_n   = (bit_buf >> sh_out) | (in_fire ? (in_ext << kept) : '0);
        count_n = kept + (in_fire ? CNT_W'(IN_W) : '0);
        if (out_fire)
          coef_n = coef_cnt + CCNT_W'(OUT_N);
        // Tail bits padding out the final input beat are dropped here.
        if (out_fire && out_last) begin
          state_n = IDLE;
          buf_n   = '0;
          count_n = '0;
          coef_n  = '0;
        end
      end
    endcase
  end

  assign out_valid_n = (state_n == RUN) && (count_n >= grp_n);
  assign out_last_n  = out_valid_n && (coef_n == CCNT_W'(N - OUT_N));

  poly_unpack_lane_extract #(
    .OUT_N  (OUT_N),
    .COEF_W (COEF_W)
  ) u_lane_extract (
    .bits  (buf_n[LANE_W-1:0]),
    .d     (d_n),
    .lanes (lanes_n)
  );

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      d_q       <= D_12;
      bit_buf   <= '0;
      count     <= '0;
      coef_cnt  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      state_q   <= state_n;
      d_q       <= d_n;
      bit_buf   <= buf_n;
      count     <= count_n;
      coef_cnt  <= coef_n;
      out_valid <= out_valid_n;
      out_last  <= out_last_n;
      out_data  <= lanes_n;
    end
  end

`ifdef POLY_UNPACK_RANGE_CHECK_EN
  logic err_n;

  always_comb begin
    err_n = 1'b0;
    if (out_valid_n && d_n == D_12)
      for (int k = 0; k < OUT_N; k++)
        if (lanes_n[k*COEF_W +: COEF_W] >= COEF_W'(KYBER_Q))
          err_n = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) out_err <= 1'b0;
    else     out_err <= err_n;
  end
`else
  assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_poly_unpack_stream.sv
// Directed bench for poly_unpack_stream: framing, widths, stalls, resets.
module tb_poly_unpack_stream;

  localparam int IN_BYTES = 12;
  localparam int OUT_N    = 8;
  localparam int COEF_W   = 16;
  localparam int N        = 256;
  localparam int IW       = 8 * IN_BYTES;
  localparam int OW       = OUT_N * COEF_W;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    d_sel;
  logic [IW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          out_err;

  logic [7:0]    stream [0:511];
  int            checks = 0;
  int            errors = 0;
  int            bin, bout;
  logic [OW-1:0] first, saved;

  always #5 clk = ~clk;

  poly_unpack_stream #(
    .IN_BYTES (IN_BYTES),
    .OUT_N    (OUT_N),
    .COEF_W   (COEF_W),
    .N        (N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .d_sel     (d_sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .out_err   (out_err)
  );

  task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [IW-1:0] beat_word(input int bi);
    logic [IW-1:0] w;
    for (int i = 0; i < IN_BYTES; i++)
      w[8*(IN_BYTES-1-i) +: 8] = stream[(bi*IN_BYTES + i) & 511];
    return w;
  endfunction

  // Coefficient idx of the stream read bit by bit, LSB-first within each byte.
  function automatic logic [COEF_W-1:0] model_coef(input int idx, input int d);
    logic [COEF_W-1:0] v;
    int pos;
    v = '0;
    for (int b = 0; b < d; b++) begin
      pos  = idx * d + b;
      v[b] = stream[pos / 8][pos % 8];
    end
    return v;
  endfunction

  function automatic logic [OW-1:0] model_word(input int ci, input int d);
    logic [OW-1:0] w;
    for (int k = 0; k < OUT_N; k++)
      w[(OUT_N-1-k)*COEF_W +: COEF_W] = model_coef(ci + k, d);
    return w;
  endfunction

  function automatic logic model_err(input logic [OW-1:0] w, input int d);
    logic e;
    e = 1'b0;
`ifdef POLY_UNPACK_RANGE_CHECK_EN
    for (int k = 0; k < OUT_N; k++)
      if (d == 12 && w[k*COEF_W +: COEF_W] >= 16'd3329) e = 1'b1;
`endif
    return e;
  endfunction

  task automatic fill_stream(input int seed);
    for (int i = 0; i < 512; i++)
      stream[i] = 8'((i * 73 + seed * 29 + (i >> 3) * seed) & 255);
  endtask

  task automatic do_reset(input logic [3:0] d);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; d_sel = d;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Feeds the current stream and checks each output beat against the model.
  // mode 0: both sides always ready; mode 1: random valid/ready.
  task automatic run_poly(input int d, input int stop_at, input int mode, input logic [3:0] next_d,
                          output int beats_in, output int beats_out, output logic [OW-1:0] first_data);
    int bi, ci, nout, cyc;
    bit done, held;
    logic [OW-1:0] held_data, exp;
    bi = 0; ci = 0; nout = 0; cyc = 0; done = 0; held = 0;
    held_data = '0; first_data = '0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (held) begin
        check($sformatf("d%0d_stall_valid", d), out_valid, 1);
        check($sformatf("d%0d_stall_data", d), out_data, held_data);
      end
      in_valid  = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      in_data   = beat_word(bi);
      out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        exp = model_word(ci, d);
        check($sformatf("d%0d_data_c%0d", d, ci), out_data, exp);
        check($sformatf("d%0d_last_c%0d", d, ci), out_last, (ci == N - OUT_N));
        check($sformatf("d%0d_err_c%0d", d, ci), out_err, model_err(exp, d));
        if (nout == 0) first_data = out_data;
        nout++;
        ci += OUT_N;
        if (ci == N) begin
          d_sel = next_d;
          done  = 1;
        end
        if (ci == stop_at) done = 1;
      end
      held      = out_valid && !out_ready;
      held_data = out_data;
      if (in_valid && in_ready) bi++;
    end
    check($sformatf("d%0d_finished", d), done, 1);
    beats_in  = bi;
    beats_out = nout;
  endtask

  initial begin
    rst = 1'b1; d_sel = 4'd12; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_err", out_err, 0);
    check("rst_out_data", out_data, 0);
    rst = 1'b0;
    check("rel_in_ready_low", in_ready, 0);
    @(negedge clk);
    check("rel_in_ready_rise", in_ready, 1);

    // D=12 first beat: 0x01,0x23,0x45 -> 0x301, 0x452.
    for (int i = 0; i < 512; i++) stream[i] = 8'(8'h01 + 8'h22 * i);
    in_valid = 1'b1;
    in_data  = beat_word(0);
    check("lat_pre_valid", out_valid, 0);
    @(negedge clk);
    in_valid = 1'b0;
    check("lat_valid", out_valid, 1);
    check("lat_lane0", out_data[OW-1 -: COEF_W], 16'h0301);
    check("lat_lane1", out_data[OW-1-COEF_W -: COEF_W], 16'h0452);
    check("lat_last", out_last, 0);
    saved = out_data;
    @(negedge clk);
    check("lat_hold_valid", out_valid, 1);
    check("lat_hold_data", out_data, saved);

    do_reset(4'd10);
    fill_stream(1);
    run_poly(10, N, 0, 4'd12, bin, bout, first);
    check("d10_beats_in", bin, 27);
    check("d10_beats_out", bout, 32);

    fill_stream(2);
    run_poly(12, N, 1, 4'd4, bin, bout, first);
    check("d12s_beats_in", bin, 32);
    check("d12s_beats_out", bout, 32);

    fill_stream(3);
    stream[0] = 8'hA7;
    run_poly(4, N, 0, 4'd0, bin, bout, first);
    check("d4_first_coef", first[OW-1 -: COEF_W], 16'h0007);
    check("d4_beats_in", bin, 11);
    check("d4_beats_out", bout, 32);

    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("illegal_d_ready", in_ready, 0);
      check("illegal_d_valid", out_valid, 0);
    end
    d_sel = 4'd12;
    @(negedge clk);
    check("legal_d_ready", in_ready, 1);

    fill_stream(4);
    run_poly(12, 96, 0, 4'd12, bin, bout, first);
    check("mid_beats_out", bout, 12);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; d_sel = 4'd5;
    @(negedge clk);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_ready", in_ready, 0);
    check("mid_rst_data", out_data, 0);
    rst = 1'b0;
    fill_stream(5);
    run_poly(5, N, 0, 4'd12, bin, bout, first);
    check("d5_beats_in", bin, 14);
    check("d5_beats_out", bout, 32);

`ifdef POLY_UNPACK_RANGE_CHECK_EN
    for (int i = 0; i < 512; i++) stream[i] = 8'h00;
    stream[0] = 8'h01; stream[1] = 8'h0D;
    do_reset(4'd12);
    @(negedge clk);
    in_valid = 1'b1; in_data = beat_word(0);
    @(negedge clk);
    in_valid = 1'b0;
    check("rc_q_lane0", out_data[OW-1 -: COEF_W], 16'h0D01);
    check("rc_q_err", out_err, 1);
    stream[0] = 8'h00;
    do_reset(4'd12);
    @(negedge clk);
    in_valid = 1'b1; in_data = beat_word(0);
    @(negedge clk);
    in_valid = 1'b0;
    check("rc_qm1_lane0", out_data[OW-1 -: COEF_W], 16'h0D00);
    check("rc_qm1_err", out_err, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
